// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word over a valid/ready
// load handshake and streams it one bit per accepted cycle. Optional even parity via PISO_TX_PARITY_EN.
module piso_shift_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH + 1);
  localparam int unsigned       OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] shifted_c;
  logic             bit_take_c;
  logic             load_take_c;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
  logic [WIDTH-1:0] par_word_c;
`endif

  // Serial view of the registered shift register.
  assign busy       = (state_q != IDLE);
  assign sout_valid = busy;
  assign sout       = shreg_q[OUT_IDX];
`ifdef PISO_TX_PARITY_EN
  assign frame_last = (state_q == PARITY);
`else
  assign frame_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`endif
  assign load_ready  = (state_q == IDLE) || (frame_last && sout_ready);
  assign bit_take_c  = sout_valid && sout_ready;
  assign load_take_c = load_valid && load_ready;

  // Shift one position toward the output end.
  always_comb begin
    shifted_c = '0;
    if (MSB_FIRST) begin
      shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity bit placed at the output end so sout still comes from the shift register.
  always_comb begin
    par_word_c          = '0;
    par_word_c[OUT_IDX] = par_q;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; a load handshake overrides the end-of-frame return to IDLE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (bit_take_c) begin
          if (cnt_q == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
            shreg_d = par_word_c;
            cnt_d   = CNT_W'(WIDTH);
`else
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
`endif
          end else begin
            shreg_d = shifted_c;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        if (bit_take_c) begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (load_take_c) begin
      state_d = SHIFT;
      shreg_d = din;
      cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: LSB-first and MSB-first instances share stimulus;
// each accepted word is expanded into its expected bit sequence and checked as bits are consumed.
module tb_piso_shift_tx;

  localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b_lsb;
    logic b_msb;
    logic last;
  } exp_t;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         load_valid = 1'b0;
  logic         sout_ready = 1'b0;
  logic [W-1:0] din        = '0;

  logic lr0, so0, sv0, fl0, bz0;
  logic lr1, so1, sv1, fl1, bz1;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic m_ev, m_elr;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr0), .din(din),
    .sout(so0), .sout_valid(sv0), .sout_ready(sout_ready), .frame_last(fl0), .busy(bz0)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr1), .din(din),
    .sout(so1), .sout_valid(sv1), .sout_ready(sout_ready), .frame_last(fl1), .busy(bz1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: expand every accepted word into its frame.
  logic [W-1:0] pw;
  always @(negedge clk) begin
    if (!rst && load_valid && lr0) begin
      pw = din;
      #1;
      for (int i = 0; i < int'(W); i++) begin
        q.push_back('{b_lsb: pw[i], b_msb: pw[int'(W) - 1 - i], last: (i == int'(W) - 1) && !PAR});
      end
      if (PAR) q.push_back('{b_lsb: ^pw, b_msb: ^pw, last: 1'b1});
    end
  end

  // Monitor: compare the presented bit against the queue front, pop on consumption.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      m_ev  = (q.size() != 0);
      m_elr = (q.size() == 0) || ((q.size() == 1) && sout_ready);
      chk("valid_lsb", sv0, m_ev);
      chk("valid_msb", sv1, m_ev);
      chk("busy_lsb", bz0, m_ev);
      chk("busy_msb", bz1, m_ev);
      chk("load_ready_lsb", lr0, m_elr);
      chk("load_ready_msb", lr1, m_elr);
      if (m_ev) begin
        chk("sout_lsb", so0, q[0].b_lsb);
        chk("sout_msb", so1, q[0].b_msb);
        chk("frame_last_lsb", fl0, q[0].last);
        chk("frame_last_msb", fl1, q[0].last);
        if (sout_ready) void'(q.pop_front());
      end else begin
        chk("idle_sout_lsb", so0, 1'b0);
        chk("idle_sout_msb", so1, 1'b0);
        chk("idle_last_lsb", fl0, 1'b0);
        chk("idle_last_msb", fl1, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return just after the edge that accepted it (load_valid left high).
  task automatic send(input logic [W-1:0] w);
    load_valid = 1'b1;
    din        = w;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lr0) begin
        tick();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL load_timeout: word %h not accepted within 200 cycles", w);
  endtask

  task automatic drain();
    load_valid = 1'b0;
    sout_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) break;
      tick();
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bits still expected", q.size());
    end
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    sout_ready = 1'b1;

    send(4'b1011);
    drain();

    // Stall while bit 1 is shown.
    send(4'b0110);
    load_valid = 1'b0;
    tick();
    sout_ready = 1'b0;
    repeat (3) tick();
    sout_ready = 1'b1;
    drain();

    // Back-to-back frames with load_valid held.
    send(4'hA);
    send(4'h5);
    drain();

    // Reset after two bits.
    send(4'hF);
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(4'h3);
    drain();

    send(4'b0111);
    drain();
    send(4'b0011);
    drain();

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      sout_ready = ($urandom_range(0, 3) != 0);
      load_valid = $urandom_range(0, 1) == 1;
      din        = W'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in/serial-out transmitter for the register datapath. It accepts a WIDTH-bit word from a parallel-load register stage over a valid/ready handshake. It shifts the word out one bit per accepted cycle on a serial valid/ready interface. It is the unload end of the team's parallel-load registers and converts a captured word into a bit stream for a downstream serial receiver.

## Interface
- WIDTH, 4: data word width, ≥ 2.
- MSB_FIRST, 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  din holds a word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- din  input  WIDTH  parallel word, sampled on load handshake.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  downstream accepts sout this cycle.
- frame_last  output  1  current serial bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state ≠ IDLE).

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being sent.
  - PARITY: only when parity is compiled in; the parity bit is being sent.
- Load handshake: a word is accepted on a rising edge where load_valid && load_ready. din is captured into the shift register, the bit counter is cleared, and the state goes to SHIFT.
- Bit handshake: a bit is consumed on an edge where sout_valid && sout_ready.
  - On consumption the shift register shifts by one toward the output end and the counter increments.
  - If sout_ready is low, sout, frame_last and the counter hold.
- sout:
  - equals shreg[0] when MSB_FIRST=0, shreg[WIDTH-1] when MSB_FIRST=1;
  - driven combinationally from the registered shift register.
- sout_valid = busy = (state ≠ IDLE).
- frame_last is high while the counter points at the final bit of the frame.
- load_ready = (state == IDLE) || (frame_last && sout_ready).
- Back-to-back loads: when the final bit is consumed on the same edge as a load handshake, the new word loads and SHIFT restarts with the counter cleared. There is no idle gap between frames.
- Final bit consumed with no load: state returns to IDLE and the shift register is cleared.
- Counter width is $clog2(WIDTH+1) and it never exceeds WIDTH.
- din is ignored outside a load handshake.

## Timing
- Reset values: state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, frame_last 0, busy 0, load_ready 1.
- Load latency: bit 0 of the frame appears on sout in the cycle immediately after the load edge.
- Throughput: one bit per cycle while sout_ready is high. A WIDTH-bit frame occupies WIDTH cycles, or WIDTH+1 with parity.
- Reset mid-frame: the frame is abandoned. The cycle after the reset edge shows the reset values, and no partial bits follow.
- rst has priority over both handshakes on the same edge.
- load_valid while busy and not on the final accepted bit: the word is not taken (load_ready=0). The upstream holds it.

## Configuration
- PISO_TX_PARITY_EN defined:
  - After the last data bit, the block enters PARITY and sends one even-parity bit, equal to the XOR of the captured word.
  - frame_last is asserted on the parity bit only.
  - The frame is WIDTH+1 bits long.
  - The parity bit is computed and registered at load time.
- PISO_TX_PARITY_EN undefined:
  - PARITY state and parity logic are absent.
  - frame_last is asserted on the last data bit.

## Test plan
- Reset, then load 4'b1011 with MSB_FIRST=0 and sout_ready=1 → sout 1,1,0,1 on four consecutive cycles; frame_last on the 4th; busy 0 and load_ready 1 the cycle after.
- MSB_FIRST=1, load 4'b1011 → sout 1,0,1,1; frame_last on the 4th bit.
- Load 4'b0110 (LSB first), drop sout_ready for 3 cycles while bit 1 is shown → sout holds 1 with sout_valid 1 for 3 cycles; the stream resumes with 1,0; no bit lost or duplicated.
- load_valid held high with 4'hA then 4'h5, sout_ready=1 → 8 contiguous valid bits 0,1,0,1,1,0,1,0; load_ready pulses on the 4th bit; no gap between frames.
- Assert rst after 2 bits of 4'hF → next cycle sout_valid 0, sout 0, load_ready 1; a new load of 4'h3 then sends 1,1,0,0.
- With PISO_TX_PARITY_EN, load 4'b0111 → sout 1,1,1,0 then parity 1; frame_last only on the 5th bit; with 4'b0011 the parity bit is 0.
